// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator CPU control path: opcode constants,
// FSM state encoding and instruction field positions.
package acc_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    // Instruction field positions: IR[15:12] opcode, IR[7:0] operand address.
    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 12;
    localparam int ADDR_MSB = 7;
    localparam int ADDR_LSB = 0;

    // Opcodes 8..E are undefined and execute as NOP.
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_JMP   = 4'h6;
    localparam logic [3:0] OP_JZ    = 4'h7;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [3:0] {
        ST_FETCH1 = 4'd0,
        ST_FETCH2 = 4'd1,
        ST_FETCH3 = 4'd2,
        ST_DECODE = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_EXEC   = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_HALT   = 4'd7
    } state_e;

    function automatic logic [3:0] ir_opcode(input logic [DATA_W-1:0] ir);
        return ir[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [ADDR_W-1:0] ir_addr(input logic [DATA_W-1:0] ir);
        return ir[ADDR_MSB:ADDR_LSB];
    endfunction

    // Instructions that read an operand from memory before EXEC.
    function automatic logic is_read_op(input logic [3:0] op);
        return (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
    endfunction

endpackage

// File: rtl/acc_control_alu.sv
// acc_alu: combinational accumulator datapath used in EXEC. Produces the new
// accumulator value for LOAD/ADD/SUB/AND (modulo 2^16) and its zero flag.
module acc_alu
    import acc_pkg::*;
(
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] mdr,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    // Select the accumulator update for the executing opcode.
    always_comb begin
        // NOTE: assign every combinational output a default first so no path
        // through the case leaves it unassigned, which would infer a latch.
        result = acc;
        case (op)
            OP_LOAD: result = mdr;
            OP_ADD:  result = acc + mdr;
            OP_SUB:  result = acc - mdr;
            OP_AND:  result = acc & mdr;
            default: result = acc;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/acc_control.sv
// acc_control: multicycle fetch/decode/execute FSM and next-state logic for
// the 8-bit-address, 16-bit-data accumulator CPU. Reads the architectural
// register bank and drives the *_next values the bank loads on the next clock.
// Only the FSM state is registered here.
// Optional feature macro: ACC_CTRL_MEMWAIT_EN (memory accesses wait for mem_ready).
module acc_control
    import acc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,

    input  logic [ADDR_W-1:0]  PC_reg,
    input  logic [ADDR_W-1:0]  MAR_reg,
    input  logic [DATA_W-1:0]  IR_reg,
    input  logic [DATA_W-1:0]  ACC_reg,
    input  logic [DATA_W-1:0]  MDR_reg,
    input  logic               Zflag_reg,

    output logic [ADDR_W-1:0]  PC_next,
    output logic [ADDR_W-1:0]  MAR_next,
    output logic [DATA_W-1:0]  IR_next,
    output logic [DATA_W-1:0]  ACC_next,
    output logic [DATA_W-1:0]  MDR_next,
    output logic               Zflag_next,

    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               mem_re,
    output logic               mem_we,
    input  logic               mem_ready,

    output logic               halted,
    output logic               illegal_op
);

    state_e state;
    state_e state_next;

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand_addr;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              access_done;

    assign opcode       = ir_opcode(IR_reg);
    assign operand_addr = ir_addr(IR_reg);

    // The memory port is addressed and fed straight from the bank.
    assign mem_addr  = MAR_reg;
    assign mem_wdata = MDR_reg;

`ifdef ACC_CTRL_MEMWAIT_EN
    // Accesses complete only on a cycle with mem_ready high.
    assign access_done = mem_ready;
`else
    // Zero-wait memory: every access completes in its first cycle.
    logic unused_mem_ready;
    assign access_done      = 1'b1;
    assign unused_mem_ready = mem_ready;
`endif

    acc_alu u_alu (
        .op     (opcode),
        .acc    (ACC_reg),
        .mdr    (MDR_reg),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // State register; synchronous reset returns the sequencer to FETCH1.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst) begin
            state <= ST_FETCH1;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, register next-values and memory strobes for the current state.
    always_comb begin
        state_next = state;
        PC_next    = PC_reg;
        MAR_next   = MAR_reg;
        IR_next    = IR_reg;
        ACC_next   = ACC_reg;
        MDR_next   = MDR_reg;
        Zflag_next = Zflag_reg;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        halted     = 1'b0;
        illegal_op = 1'b0;

        if (rst) begin
            // Abandon any instruction; the bank clears itself this cycle.
            state_next = ST_FETCH1;
        end else begin
            case (state)
                ST_FETCH1: begin
                    MAR_next   = PC_reg;
                    state_next = ST_FETCH2;
                end

                ST_FETCH2: begin
                    mem_re = 1'b1;
                    if (access_done) begin
                        MDR_next   = mem_rdata;
                        state_next = ST_FETCH3;
                    end
                end

                ST_FETCH3: begin
                    IR_next    = MDR_reg;
                    PC_next    = PC_reg + 8'd1;
                    state_next = ST_DECODE;
                end

                ST_DECODE: begin
                    state_next = ST_FETCH1;
                    if (is_read_op(opcode)) begin
                        MAR_next   = operand_addr;
                        state_next = ST_MEMRD;
                    end else begin
                        case (opcode)
                            OP_NOP: ;
                            OP_STORE: begin
                                MAR_next   = operand_addr;
                                MDR_next   = ACC_reg;
                                state_next = ST_MEMWR;
                            end
                            OP_JMP: PC_next = operand_addr;
                            OP_JZ: begin
                                if (Zflag_reg) begin
                                    PC_next = operand_addr;
                                end
                            end
                            OP_HALT: state_next = ST_HALT;
                            default: illegal_op = 1'b1;
                        endcase
                    end
                end

                ST_MEMRD: begin
                    mem_re = 1'b1;
                    if (access_done) begin
                        MDR_next   = mem_rdata;
                        state_next = ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    ACC_next   = alu_result;
                    Zflag_next = alu_zero;
                    state_next = ST_FETCH1;
                end

                ST_MEMWR: begin
                    mem_we = 1'b1;
                    if (access_done) begin
                        state_next = ST_FETCH1;
                    end
                end

                ST_HALT: begin
                    halted = 1'b1;
                end

                default: begin
                    state_next = ST_FETCH1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_control.sv
// Directed bench for acc_control. Supplies a register bank (synchronous reset
// to zero) and a 256-word memory around the controller and walks a small
// program through every opcode, checking registers, strobes and cycle counts.
module tb_acc_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  PC_reg, MAR_reg, PC_next, MAR_next;
    logic [15:0] IR_reg, ACC_reg, MDR_reg, IR_next, ACC_next, MDR_next;
    logic        Zflag_reg, Zflag_next;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        mem_re, mem_we, mem_ready;
    logic        halted, illegal_op;

    logic [15:0] mem [256] = '{default: 16'h0000};
    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [15:0] pl_data;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    acc_control dut (
        .clk        (clk),
        .rst        (rst),
        .PC_reg     (PC_reg),
        .MAR_reg    (MAR_reg),
        .IR_reg     (IR_reg),
        .ACC_reg    (ACC_reg),
        .MDR_reg    (MDR_reg),
        .Zflag_reg  (Zflag_reg),
        .PC_next    (PC_next),
        .MAR_next   (MAR_next),
        .IR_next    (IR_next),
        .ACC_next   (ACC_next),
        .MDR_next   (MDR_next),
        .Zflag_next (Zflag_next),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_ready  (mem_ready),
        .halted     (halted),
        .illegal_op (illegal_op)
    );

    assign mem_rdata = mem[mem_addr];

    // Register bank: clears on reset, otherwise loads the controller's next values.
    always @(posedge clk) begin
        if (rst) begin
            PC_reg <= '0; MAR_reg <= '0; IR_reg <= '0;
            ACC_reg <= '0; MDR_reg <= '0; Zflag_reg <= 1'b0;
        end else begin
            PC_reg <= PC_next; MAR_reg <= MAR_next; IR_reg <= IR_next;
            ACC_reg <= ACC_next; MDR_reg <= MDR_next; Zflag_reg <= Zflag_next;
        end
    end

    // Memory: bench preload port, otherwise controller writes.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    // Starting in FETCH1: confirm the fetch of pc, leaving the FSM in FETCH3.
    task automatic fetch(input logic [7:0] pc);
        check("f1_re", {15'd0, mem_re}, 16'd0);
        check("f1_mar_next", {8'd0, MAR_next}, {8'd0, pc});
        tick();
        check("f2_re", {15'd0, mem_re}, 16'd1);
        check("f2_addr", {8'd0, mem_addr}, {8'd0, pc});
        tick();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    // Watchdog: every step is a fixed cycle count, so this only guards the bench.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int strobes;
        rst = 1'b1; mem_ready = 1'b1;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        tick();

        // Program image.
        preload(8'h00, 16'h1010);  // LOAD 10
        preload(8'h01, 16'h7040);  // JZ 40 (taken)
        preload(8'h10, 16'h0000);
        preload(8'h11, 16'hFFFF);
        preload(8'h12, 16'h0001);
        preload(8'h13, 16'hBEEF);
        preload(8'h14, 16'h0F0F);
        preload(8'h40, 16'h1012);  // LOAD 12
        preload(8'h41, 16'h3011);  // ADD 11
        preload(8'h42, 16'h1012);  // LOAD 12
        preload(8'h43, 16'h4011);  // SUB 11
        preload(8'h44, 16'h7050);  // JZ 50 (not taken)
        preload(8'h45, 16'h1013);  // LOAD 13
        preload(8'h46, 16'h2020);  // STORE 20
        preload(8'h47, 16'h5014);  // AND 14
        preload(8'h48, 16'h9000);  // illegal
        preload(8'h49, 16'h0000);  // NOP
        preload(8'h4A, 16'h60FF);  // JMP FF
        preload(8'hFF, 16'h6060);  // JMP 60
        preload(8'h60, 16'hF000);  // HALT

        // Reset state.
        check("rst_re", {15'd0, mem_re}, 16'd0);
        check("rst_we", {15'd0, mem_we}, 16'd0);
        check("rst_halted", {15'd0, halted}, 16'd0);
        check("rst_pc_next", {8'd0, PC_next}, 16'h0000);
        rst = 1'b0;

        // LOAD 10 -> ACC 0, Z 1, PC 1, six cycles.
        fetch(8'h00); run(4);
        check("load0_acc", ACC_reg, 16'h0000);
        check("load0_z", {15'd0, Zflag_reg}, 16'd1);
        check("load0_pc", {8'd0, PC_reg}, 16'h0001);

        // JZ 40 with Z=1 -> taken, four cycles.
        fetch(8'h01); run(2);
        check("jz_taken_pc", {8'd0, PC_reg}, 16'h0040);

        fetch(8'h40); run(4);
        check("load1_acc", ACC_reg, 16'h0001);
        check("load1_z", {15'd0, Zflag_reg}, 16'd0);

        // ADD FFFF to 1 wraps to 0.
        fetch(8'h41); run(4);
        check("add_acc", ACC_reg, 16'h0000);
        check("add_z", {15'd0, Zflag_reg}, 16'd1);
        check("add_pc", {8'd0, PC_reg}, 16'h0042);

        fetch(8'h42); run(4);
        // SUB: 1 - FFFF = 0002.
        fetch(8'h43); run(4);
        check("sub_acc", ACC_reg, 16'h0002);
        check("sub_z", {15'd0, Zflag_reg}, 16'd0);

        // JZ 50 with Z=0 -> falls through.
        fetch(8'h44); run(2);
        check("jz_nt_pc", {8'd0, PC_reg}, 16'h0045);

        fetch(8'h45); run(4);
        check("load_beef", ACC_reg, 16'hBEEF);

        // STORE 20: single write strobe, five cycles total.
        fetch(8'h46);
        tick();
        check("st_dec_we", {15'd0, mem_we}, 16'd0);
        tick();
        check("st_we", {15'd0, mem_we}, 16'd1);
        check("st_addr", {8'd0, mem_addr}, 16'h0020);
        check("st_wdata", mem_wdata, 16'hBEEF);
        tick();
        check("st_we_off", {15'd0, mem_we}, 16'd0);
        check("st_mem", mem[8'h20], 16'hBEEF);
        check("st_z_kept", {15'd0, Zflag_reg}, 16'd0);

        // AND: BEEF & 0F0F = 0E0F.
        fetch(8'h47); run(4);
        check("and_acc", ACC_reg, 16'h0E0F);
        check("and_z", {15'd0, Zflag_reg}, 16'd0);

        // Illegal opcode 9: one-cycle pulse in DECODE, otherwise NOP.
        fetch(8'h48);
        check("ill_fetch3", {15'd0, illegal_op}, 16'd0);
        tick();
        check("ill_pulse", {15'd0, illegal_op}, 16'd1);
        tick();
        check("ill_after", {15'd0, illegal_op}, 16'd0);
        check("ill_pc", {8'd0, PC_reg}, 16'h0049);
        check("ill_acc", ACC_reg, 16'h0E0F);

        fetch(8'h49); run(2);
        check("nop_pc", {8'd0, PC_reg}, 16'h004A);

        fetch(8'h4A); run(2);
        check("jmp_pc", {8'd0, PC_reg}, 16'h00FF);

        // Fetch at FF: PC wraps to 00, then JMP 60.
        fetch(8'hFF);
        tick();
        check("pc_wrap", {8'd0, PC_reg}, 16'h0000);
        tick();
        check("jmp_wrap_pc", {8'd0, PC_reg}, 16'h0060);

        // HALT: halted high, no strobes for 20 cycles.
        fetch(8'h60);
        tick();
        tick();
        check("halt_flag", {15'd0, halted}, 16'd1);
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            if (mem_re || mem_we) strobes++;
            tick();
        end
        check("halt_strobes", strobes[15:0], 16'd0);
        check("halt_hold", {15'd0, halted}, 16'd1);
        check("halt_pc", {8'd0, PC_reg}, 16'h0061);

        // Reset out of HALT: halted drops, fetch restarts at 0.
        rst = 1'b1;
        #1;
        check("rst_halted_low", {15'd0, halted}, 16'd0);
        tick();
        rst = 1'b0;
        fetch(8'h00);

        // Reset in MEMRD drops the read strobe at once.
        tick();
        tick();
        check("memrd_re", {15'd0, mem_re}, 16'd1);
        check("memrd_addr", {8'd0, mem_addr}, 16'h0010);
        rst = 1'b1;
        #1;
        check("memrd_rst_re", {15'd0, mem_re}, 16'd0);
        tick();
        rst = 1'b0;
        fetch(8'h00); run(4);
        check("restart_z", {15'd0, Zflag_reg}, 16'd1);
        check("restart_pc", {8'd0, PC_reg}, 16'h0001);

`ifdef ACC_CTRL_MEMWAIT_EN
        // Three wait cycles in MEMRD: strobe held 4 cycles, LOAD takes 9.
        rst = 1'b1; tick(); rst = 1'b0;
        fetch(8'h00);
        tick();
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("wait_re", {15'd0, mem_re}, 16'd1);
            tick();
        end
        mem_ready = 1'b1;
        check("wait_re_last", {15'd0, mem_re}, 16'd1);
        tick();
        check("wait_exec_re", {15'd0, mem_re}, 16'd0);
        tick();
        check("wait_acc", ACC_reg, 16'h0000);
        check("wait_z", {15'd0, Zflag_reg}, 16'd1);
        fetch(8'h01);

        // Reset while waiting: strobe drops and the FSM restarts in FETCH1.
        rst = 1'b1; tick(); rst = 1'b0;
        fetch(8'h00);
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        check("wait2_re", {15'd0, mem_re}, 16'd1);
        rst = 1'b1;
        #1;
        check("wait2_rst_re", {15'd0, mem_re}, 16'd0);
        tick();
        rst = 1'b0;
        mem_ready = 1'b1;
        fetch(8'h00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
